// File: rtl/circuito_jogo_param_if.sv
// Player-facing signal bundle of the memory-sequence game core.
// master = board/bench side, slave = game core.
interface circuito_jogo_param_if #(
  parameter int N_CHAVES = 4
);
  logic                iniciar;
  logic                modo;
  logic [N_CHAVES-1:0] chaves;
  logic                ganhou;
  logic                perdeu;
  logic                pronto;
  logic [N_CHAVES-1:0] leds;
  logic [3:0]          db_estado;
  logic [7:0]          db_rodada;
  logic                db_timeout;

  modport master (
    output iniciar, modo, chaves,
    input  ganhou, perdeu, pronto, leds, db_estado, db_rodada, db_timeout
  );

  modport slave (
    input  iniciar, modo, chaves,
    output ganhou, perdeu, pronto, leds, db_estado, db_rodada, db_timeout
  );
endinterface

// File: rtl/circuito_jogo_param.sv
// Memory-sequence game core: control FSM, sequence RAM, show/timeout timer,
// key-edge detection and free-running LFSR symbol source.
module circuito_jogo_param #(
  parameter int         N_CHAVES  = 4,
  parameter int         N_RODADAS = 16,
  parameter int         TIMEOUT   = 5000,
  parameter int         T_MOSTRA  = 1000,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input logic                   clock,
  input logic                   reset,
  circuito_jogo_param_if.slave  bus
);
  localparam int W  = $clog2(N_CHAVES);
  localparam int AW = $clog2(N_RODADAS);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA_ON   = 4'd2,
    MOSTRA_OFF  = 4'd3,
    ESPERA      = 4'd4,
    REGISTRA    = 4'd5,
    COMPARA     = 4'd6,
    ESPERA_NOVA = 4'd7,
    FIM_GANHOU  = 4'd8,
    FIM_PERDEU  = 4'd9
  } estado_t;

  estado_t             r_estado, w_prox;
  logic [7:0]          r_lfsr;
  logic [7:0]          r_rodada, w_rodada_nx;
  logic [7:0]          r_endereco, w_endereco_nx;
  logic [31:0]         r_timer;
  logic [N_CHAVES-1:0] r_chaves_ant, r_jogada;
  logic                r_modo, w_modo_nx;
  logic                r_timeout, w_timeout_nx;
  logic                w_latch;
  logic                w_we;
  logic [7:0]          w_waddr;
  logic [W-1:0]        w_wdata;
  logic [W-1:0]        r_mem [N_RODADAS];

  logic                w_jogada, w_um_bit, w_ultimo, w_fim_rod;
  logic                w_t_mostra, w_t_out, w_timed;
  logic [W-1:0]        w_idx, w_sym;
  logic [N_CHAVES-1:0] w_oh_mem;
  logic [7:0]          w_rodada_inc;

  // Key event = rising edge of "any key pressed"; holding keys yields one event.
  assign w_jogada     = (|bus.chaves) & ~(|r_chaves_ant);
  assign w_um_bit     = (|bus.chaves) & ((bus.chaves & (bus.chaves - N_CHAVES'(1))) == '0);
  assign w_sym        = r_mem[r_endereco[AW-1:0]];
  assign w_oh_mem     = N_CHAVES'(1) << w_sym;
  assign w_ultimo     = (r_endereco == r_rodada);
  assign w_fim_rod    = (r_rodada == 8'(N_RODADAS - 1));
  assign w_t_mostra   = (r_timer == 32'(T_MOSTRA - 1));
  assign w_t_out      = (r_timer == 32'(TIMEOUT - 1));
  assign w_rodada_inc = r_rodada + 8'd1;
  assign w_timed      = (r_estado == MOSTRA_ON) || (r_estado == MOSTRA_OFF) ||
                        (r_estado == ESPERA)    || (r_estado == ESPERA_NOVA);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_CHAVES; i++)
      if (bus.chaves[i]) w_idx = W'(i);
  end

  always_comb begin
    w_prox        = r_estado;
    w_rodada_nx   = r_rodada;
    w_endereco_nx = r_endereco;
    w_modo_nx     = r_modo;
    w_timeout_nx  = r_timeout;
    w_latch       = 1'b0;
    w_we          = 1'b0;
    w_waddr       = r_rodada;
    w_wdata       = r_lfsr[W-1:0];
    case (r_estado)
      INICIAL, FIM_GANHOU, FIM_PERDEU: begin
        if (bus.iniciar) begin
          w_prox        = PREPARA;
          w_rodada_nx   = '0;
          w_endereco_nx = '0;
          w_timeout_nx  = 1'b0;
          w_modo_nx     = bus.modo;
        end
      end
      PREPARA: begin
        w_we          = 1'b1;
        w_endereco_nx = '0;
        w_prox        = MOSTRA_ON;
      end
      MOSTRA_ON: if (w_t_mostra) w_prox = MOSTRA_OFF;
      MOSTRA_OFF: begin
        if (w_t_mostra) begin
          if (w_ultimo) begin
            w_endereco_nx = '0;
            w_prox        = ESPERA;
          end else begin
            w_endereco_nx = r_endereco + 8'd1;
            w_prox        = MOSTRA_ON;
          end
        end
      end
      // A key event in the last allowed cycle beats the timeout.
      ESPERA: begin
        if (w_jogada) begin
          w_latch = 1'b1;
          w_prox  = REGISTRA;
        end else if (w_t_out) begin
          w_timeout_nx = 1'b1;
          w_prox       = FIM_PERDEU;
        end
      end
      REGISTRA: w_prox = COMPARA;
      COMPARA: begin
        if (r_jogada != w_oh_mem)
          w_prox = FIM_PERDEU;
        else if (!w_ultimo) begin
          w_endereco_nx = r_endereco + 8'd1;
          w_prox        = ESPERA;
        end else if (w_fim_rod)
          w_prox = FIM_GANHOU;
        else if (!r_modo) begin
          w_rodada_nx = w_rodada_inc;
          w_prox      = PREPARA;
        end else
          w_prox = ESPERA_NOVA;
      end
      ESPERA_NOVA: begin
        if (w_jogada) begin
          if (w_um_bit) begin
            w_we          = 1'b1;
            w_waddr       = w_rodada_inc;
            w_wdata       = w_idx;
            w_rodada_nx   = w_rodada_inc;
            w_endereco_nx = '0;
            w_prox        = MOSTRA_ON;
          end else
            w_prox = FIM_PERDEU;
        end else if (w_t_out) begin
          w_timeout_nx = 1'b1;
          w_prox       = FIM_PERDEU;
        end
      end
      default: w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado     <= INICIAL;
      r_lfsr       <= SEED;
      r_rodada     <= '0;
      r_endereco   <= '0;
      r_timer      <= '0;
      r_chaves_ant <= '0;
      r_jogada     <= '0;
      r_modo       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_estado     <= w_prox;
      r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_rodada     <= w_rodada_nx;
      r_endereco   <= w_endereco_nx;
      r_chaves_ant <= bus.chaves;
      r_modo       <= w_modo_nx;
      r_timeout    <= w_timeout_nx;
      if (w_latch) r_jogada <= bus.chaves;
      // Timer restarts on every state change and idles outside timed states.
      r_timer      <= (w_prox != r_estado || !w_timed) ? '0 : r_timer + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_waddr[AW-1:0]] <= w_wdata;
  end

  assign bus.ganhou     = (r_estado == FIM_GANHOU);
  assign bus.perdeu     = (r_estado == FIM_PERDEU);
  assign bus.pronto     = (r_estado == FIM_GANHOU) || (r_estado == FIM_PERDEU);
  assign bus.leds       = (r_estado == MOSTRA_ON) ? w_oh_mem : '0;
  assign bus.db_estado  = r_estado;
  assign bus.db_rodada  = r_rodada;
  assign bus.db_timeout = r_timeout;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// Bench for circuito_jogo_param: table vectors for the first move, directed
// corner sequences and randomized games scored by a sequence-level model.
module tb_circuito_jogo_param;
  localparam int         NK   = 4;
  localparam int         NR   = 4;
  localparam int         TO   = 20;
  localparam int         TM   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  circuito_jogo_param_if #(.N_CHAVES(NK)) bus ();

  circuito_jogo_param #(
    .N_CHAVES(NK), .N_RODADAS(NR), .TIMEOUT(TO), .T_MOSTRA(TM), .SEED(SEED)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_lfsr  = SEED;
  int         seq [NR];

  typedef struct {
    int         kind;   // 0 correct key, 1 given key, 2 no key, 3 wrong single key
    logic [3:0] key;
    int         dly;
    int         st;
    int         perd;
    int         tmo;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [3:0] oh(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; the model LFSR advances exactly as the spec's shift rule says.
  task automatic tick();
    @(posedge clock);
    if (reset) m_lfsr = SEED;
    else       m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    #1;
  endtask

  task automatic idle(input int n);
    bus.chaves = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.iniciar = 1'b0; bus.chaves = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic m);
    bus.iniciar = 1'b1; bus.modo = m;
    tick();
    bus.iniciar = 1'b0; bus.modo = ~m;
    chk("start_state", int'(bus.db_estado), 1);
    chk("start_timeout", int'(bus.db_timeout), 0);
    chk("start_rodada", int'(bus.db_rodada), 0);
    seq[0] = int'(m_lfsr[1:0]);
  endtask

  // Display of round r: each symbol TM cycles lit then TM dark, then espera.
  task automatic show(input int r, input bit skip);
    for (int e = 0; e <= r; e++)
      for (int c = 0; c < 2 * TM; c++) begin
        if (!(skip && e == 0 && c == 0)) tick();
        if (c < TM) chk("leds_on", int'(bus.leds), int'(oh(seq[e])));
        else        chk("leds_off", int'(bus.leds), 0);
      end
    tick();
    chk("espera_entry", int'(bus.db_estado), 4);
  endtask

  task automatic press(input logic [3:0] k);
    bus.chaves = k;
    tick();
    bus.chaves = '0;
    chk("registra", int'(bus.db_estado), 5);
    tick();
    chk("compara", int'(bus.db_estado), 6);
    tick();
  endtask

  // Full game; forced fault at (fr,fe): fk 0 wrong key, 1 two keys, 2 timeout.
  // fe == r+1 targets espera_nova in modo 1. pw = % chance of a random key.
  task automatic game(input logic m, input int fr, input int fe, input int fk, input int pw);
    int r, cur, j;
    bit alive;
    logic [3:0] k, want;
    do_reset();
    start(m);
    show(0, 1'b0);
    r = 0; alive = 1'b1;
    while (alive) begin
      cur = r;
      for (int e = 0; e <= cur && alive; e++) begin
        want = oh(seq[e]);
        if (fr == r && fe == e && fk == 2) begin
          idle(TO - 1);
          chk("to_hold", int'(bus.db_estado), 4);
          tick();
          chk("to_state", int'(bus.db_estado), 9);
          chk("to_flag", int'(bus.db_timeout), 1);
          chk("to_perdeu", int'(bus.perdeu), 1);
          alive = 1'b0;
        end else begin
          if (fr == r && fe == e)                k = (fk == 1) ? 4'b0011 : {want[2:0], want[3]};
          else if ($urandom_range(0, 99) < pw)   k = 4'($urandom_range(1, 15));
          else                                   k = want;
          idle($urandom_range(0, TO - 1));
          press(k);
          if (k != want) begin
            chk("lose_state", int'(bus.db_estado), 9);
            chk("lose_perdeu", int'(bus.perdeu), 1);
            chk("lose_pronto", int'(bus.pronto), 1);
            chk("lose_timeout", int'(bus.db_timeout), 0);
            alive = 1'b0;
          end else if (e < r) begin
            chk("next_move", int'(bus.db_estado), 4);
          end else if (r == NR - 1) begin
            chk("win_state", int'(bus.db_estado), 8);
            chk("win_ganhou", int'(bus.ganhou), 1);
            chk("win_pronto", int'(bus.pronto), 1);
            chk("win_rodada", int'(bus.db_rodada), NR - 1);
            alive = 1'b0;
          end else if (!m) begin
            chk("prepara", int'(bus.db_estado), 1);
            chk("rodada_inc", int'(bus.db_rodada), r + 1);
            seq[r + 1] = int'(m_lfsr[1:0]);
            r++;
            show(r, 1'b0);
          end else begin
            chk("espera_nova", int'(bus.db_estado), 7);
            if (fr == r && fe == r + 1 && fk == 2) begin
              idle(TO - 1);
              chk("nova_to_hold", int'(bus.db_estado), 7);
              tick();
              chk("nova_to_state", int'(bus.db_estado), 9);
              chk("nova_to_flag", int'(bus.db_timeout), 1);
              alive = 1'b0;
            end else begin
              j = (r == 0) ? 2 : int'($urandom_range(0, 3));
              k = (fr == r && fe == r + 1) ? 4'b0011 : oh(j);
              idle($urandom_range(0, TO - 1));
              bus.chaves = k;
              tick();
              bus.chaves = '0;
              if (k == 4'b0011) begin
                chk("nova_multi", int'(bus.db_estado), 9);
                chk("nova_multi_perdeu", int'(bus.perdeu), 1);
                alive = 1'b0;
              end else begin
                chk("nova_show", int'(bus.db_estado), 2);
                chk("nova_rodada", int'(bus.db_rodada), r + 1);
                seq[r + 1] = j;
                r++;
                show(r, 1'b1);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [3:0] want;
    vecs[0] = '{0, 4'h0,      0, 1, 0, 0};
    vecs[1] = '{0, 4'h0, TO - 1, 1, 0, 0};
    vecs[2] = '{1, 4'b0011,   3, 9, 1, 0};
    vecs[3] = '{1, 4'b1111,   0, 9, 1, 0};
    vecs[4] = '{3, 4'h0,      5, 9, 1, 0};
    vecs[5] = '{2, 4'h0,     TO, 9, 1, 1};

    bus.iniciar = 1'b0; bus.modo = 1'b0; bus.chaves = '0;
    tick();
    chk("rst_state", int'(bus.db_estado), 0);
    chk("rst_leds", int'(bus.leds), 0);
    chk("rst_outs", int'({bus.ganhou, bus.perdeu, bus.pronto, bus.db_timeout}), 0);
    chk("rst_rodada", int'(bus.db_rodada), 0);
    reset = 1'b0;
    tick();
    chk("idle_inicial", int'(bus.db_estado), 0);

    foreach (vecs[i]) begin
      do_reset();
      start(1'b0);
      show(0, 1'b0);
      want = oh(seq[0]);
      idle(vecs[i].dly);
      case (vecs[i].kind)
        0:       press(want);
        1:       press(vecs[i].key);
        3:       press({want[2:0], want[3]});
        default: ;
      endcase
      chk("vec_state", int'(bus.db_estado), vecs[i].st);
      chk("vec_perdeu", int'(bus.perdeu), vecs[i].perd);
      chk("vec_timeout", int'(bus.db_timeout), vecs[i].tmo);
    end

    game(1'b0, -1, -1, 0, 0);   // modo 0 clean win
    game(1'b0,  2,  1, 0, 0);   // round 2, second move wrong
    game(1'b0,  0,  0, 1, 0);   // two keys at once
    game(1'b0,  1,  0, 2, 0);   // timeout in espera
    start(1'b0);                // restart from fim_perdeu clears db_timeout
    game(1'b1, -1, -1, 0, 0);   // modo 1 clean win, first added key 0100
    game(1'b1,  1,  2, 1, 0);   // modo 1 two keys in espera_nova
    game(1'b1,  0,  1, 2, 0);   // modo 1 timeout in espera_nova

    // Key held from display into espera must not count until re-pressed.
    do_reset();
    start(1'b0);
    want = oh(seq[0]);
    bus.chaves = want;
    show(0, 1'b0);
    repeat (3) begin
      tick();
      chk("held_no_event", int'(bus.db_estado), 4);
    end
    bus.chaves = '0;
    tick();
    press(want);
    chk("held_repress", int'(bus.db_estado), 1);

    // Reset in the middle of a display.
    do_reset();
    start(1'b0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("midrst_state", int'(bus.db_estado), 0);
    chk("midrst_leds", int'(bus.leds), 0);
    tick();
    reset = 1'b0;
    chk("midrst_rodada", int'(bus.db_rodada), 0);

    for (int g = 0; g < 8; g++)
      game(1'($urandom_range(0, 1)), -1, -1, 0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/circuito_jogo_param.md
# circuito_jogo_param

Parametrised successor of the memory-sequence game top: a single block holding the control FSM, sequence RAM, show/timeout timers and key-edge detection. It generalises the key count, maximum round count and timer lengths, generates the sequence internally from an LFSR, and adds a second mode where the player extends the sequence each round. It is the game's top-level core; the board wrapper adds 7-segment decoding of the debug outputs.

## Interface
Parameters:
- N_CHAVES, 4: keys/LEDs; power of 2, 2..8; symbol width W = log2(N_CHAVES)
- N_RODADAS, 16: rounds needed to win, 2..256
- TIMEOUT, 5000: cycles allowed per player move
- T_MOSTRA, 1000: cycles each shown LED is on, and cycles of blank gap after it
- SEED, 8'hA5: LFSR reset value, nonzero

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- iniciar  in  1  start/restart level, sampled in inicial and final states
- modo  in  1  0 = LFSR appends each round; 1 = player appends; captured when iniciar is accepted
- chaves  in  N_CHAVES  player keys
- ganhou  out  1  high in fim_ganhou
- perdeu  out  1  high in fim_perdeu
- pronto  out  1  high in fim_ganhou/fim_perdeu
- leds  out  N_CHAVES  one-hot display of the shown symbol
- db_estado  out  4  state code
- db_rodada  out  8  current round index (0-based)
- db_timeout  out  1  sticky: last game ended by timeout

## Operation
- States/codes: inicial 0, prepara 1, mostra_on 2, mostra_off 3, espera 4, registra 5, compara 6, espera_nova 7, fim_ganhou 8, fim_perdeu 9.
- LFSR: 8-bit, free-running every cycle from reset: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Symbol = lfsr[W-1:0].
- RAM: N_RODADAS x W, written only by FSM.
- Key event: jogada = (|chaves) & ~(|chaves_ant); chaves_ant is a register (reset 0). Holding keys produces one event. Valid only if chaves is one-hot; multiple bits set = wrong move.
- inicial: iniciar -> prepara; clears rodada, endereco, db_timeout; latches modo.
- prepara (1 cycle): mem[rodada] <= symbol; -> mostra_on with endereco = 0. In modo 1 entered only for rodada 0.
- mostra_on (T_MOSTRA cycles, leds = onehot(mem[endereco])) -> mostra_off (T_MOSTRA cycles, leds = 0); then if endereco == rodada -> espera with endereco = 0, else endereco+1 -> mostra_on.
- espera: timer counts; jogada -> registra (latch chaves); TIMEOUT cycles without jogada -> fim_perdeu, db_timeout = 1.
- registra (1 cycle) -> compara.
- compara: wrong -> fim_perdeu. Correct and endereco < rodada -> endereco+1, timer cleared, -> espera. Correct and endereco == rodada: if rodada == N_RODADAS-1 -> fim_ganhou; else if modo 0 -> rodada+1, -> prepara; else -> espera_nova.
- espera_nova (modo 1): timer cleared on entry; valid one-hot jogada -> mem[rodada+1] <= index of the set key, rodada+1, endereco = 0, -> mostra_on; multi-bit jogada -> fim_perdeu; timeout -> fim_perdeu, db_timeout = 1.
- fim states: outputs held; iniciar -> prepara (restart as from inicial, modo recaptured).

## Timing
- Reset: state inicial, all outputs 0, leds 0, rodada/endereco/timer 0, lfsr = SEED, db_timeout 0.
- Moore outputs, registered state; outputs change the cycle after the transition edge.
- Key edge at cycle k (chaves sampled) -> registra at k+1 -> compara at k+2 -> next state at k+3.
- Timeout: entering espera at cycle t with no jogada -> fim_perdeu at t+TIMEOUT.
- Each shown symbol occupies exactly 2*T_MOSTRA cycles; round r display lasts (r+1)*2*T_MOSTRA cycles.
- Key events during mostra_on/mostra_off/prepara are ignored; chaves_ant still tracks them (holding a key across display start yields no event).
- Jogada and timeout expiring in the same cycle: jogada wins.
- reset mid-game: immediate return to reset values.

## Test plan
- Reset then iniciar, modo 0, N_CHAVES 4, T_MOSTRA 4: leds shows onehot(model symbol) for 4 cycles, 0 for 4, then state 4.
- modo 0, bench model of LFSR answers all rounds correctly, N_RODADAS 4 -> ganhou = pronto = 1, db_rodada = 3, state 8.
- Round 2, second move wrong key (e.g. 4'b1000 vs expected 4'b0001) -> perdeu = 1, state 9, db_timeout = 0.
- No key for TIMEOUT = 20 cycles in espera -> fim_perdeu exactly 20 cycles after entry, db_timeout = 1; iniciar -> state 1, db_timeout = 0.
- modo 1: replay round 0, press 4'b0100 in espera_nova -> next display shows mem[0] then 4'b0100; db_rodada = 1.
- Two keys pressed together (4'b0011) in espera -> perdeu; key held from mostra into espera -> no event until released and re-pressed.
